lms_conv_monitor: RTL

downstream stage of the 4-tap LMS adaptive filter. Consumes the filter error stream, computes a windowed mean-absolute-error (MAE) and peak error, and reports convergence, loss of lock and divergence.

Interface
- REQ-001 Parameter WIN_LOG2, default 4; window length is 2^WIN_LOG2 samples; legal range 1..8.
- REQ-002 Parameter THR_LO, default 10'd16; MAE must be strictly below this to count as a good window.
- REQ-003 Parameter THR_HI, default 10'd48; MAE at or above this while locked means loss of lock; THR_HI >= THR_LO.
- REQ-004 Parameter HOLD, default 3; number of consecutive good windows required to lock; legal range 1..15.
- REQ-005 Parameter DIV_LIM, default 10'd500; a window peak |err| at or above this means divergence.
- REQ-006 clk  input  1  sole clock; all logic on rising edge.
- REQ-007 rst  input  1  reset; synchronous, active-low.
- REQ-008 en  input  1  sample strobe; errr is valid when en=1.
- REQ-009 clr  input  1  synchronous clear of monitor state; rst is not affected.
- REQ-010 errr  input  10 signed  filter error sample, connected to the filter's errr output.
- REQ-011 mae_out  output  10 unsigned  MAE of the last completed window.
- REQ-012 peak_out  output  10 unsigned  peak |errr| of the last completed window.
- REQ-013 mae_valid  output  1  one-cycle pulse when mae_out and peak_out update.
- REQ-014 converged  output  1  level; high while in state LOCK.
- REQ-015 lost  output  1  one-cycle pulse on the LOCK->ACQ transition.
- REQ-016 diverge  output  1  sticky alarm; high in state FAULT.
- REQ-017 win_cnt  output  16 unsigned  completed windows since reset or clr; saturates at 16'hFFFF.
- REQ-018 state  output  2  encoding IDLE=0, ACQ=1, LOCK=2, FAULT=3.

Function
- REQ-019 |errr| SHALL be computed as a 10-bit unsigned value; -512 maps to 512 with no wrap.
- REQ-020 On each cycle with en=1 outside FAULT, |errr| SHALL be added to an accumulator of width 10+WIN_LOG2, and the peak register SHALL take max(peak, |errr|).
- REQ-021 A sample counter of width WIN_LOG2 SHALL increment per accepted sample and wrap to 0 after 2^WIN_LOG2-1.
- REQ-022 When the last sample of a window (counter = 2^WIN_LOG2-1) is accepted in cycle n, the following SHALL occur in cycle n+1: mae_out = (acc + |errr|) >> WIN_LOG2 (truncating), peak_out = final peak, mae_valid = 1, and win_cnt incremented.
- REQ-023 The accumulator and peak SHALL restart at 0 for the next window, so a sample accepted in cycle n+1 is the first sample of the new window; no sample is lost or double-counted.
- REQ-024 Cycles with en=0 SHALL hold the accumulator, peak and counter unchanged; windows count samples, not cycles.
- REQ-025 IDLE: the first en=1 SHALL move to ACQ, and that sample SHALL be accumulated.
- REQ-026 ACQ, at each window end:
  - MAE < THR_LO increments good_cnt; otherwise good_cnt = 0.
  - When good_cnt reaches HOLD, the state moves to LOCK and converged=1, taking effect in the same cycle as mae_valid.
- REQ-027 LOCK: at a window end with MAE >= THR_HI, the state moves to ACQ, good_cnt = 0, converged = 0 and lost pulses for one cycle; MAE in [THR_LO, THR_HI) stays in LOCK (hysteresis).
- REQ-028 ACQ or LOCK: at a window end with peak >= DIV_LIM, the state moves to FAULT, diverge = 1 and converged = 0. This takes priority over REQ-026 and REQ-027, and lost SHALL NOT pulse.
- REQ-029 FAULT is held until clr or rst; en is ignored, and outputs other than diverge and state hold their values.
- REQ-030 clr=1 SHALL clear the accumulator, peak, counter, good_cnt, win_cnt, mae_out, peak_out and diverge, and move the state to IDLE; the sample presented with clr is discarded.
- REQ-031 Priority: rst over clr over en.
- REQ-032 mae_valid and lost SHALL be registered outputs with no combinational path from any input.

Reset
- REQ-033 With rst=0 at a rising edge, the following SHALL be forced:
  - state = IDLE;
  - mae_out, peak_out, win_cnt, accumulator, counter and good_cnt = 0;
  - m

---
 rtl/lms_conv_monitor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lms_conv_monitor.sv
// rtl/lms_conv_monitor.sv - windowed MAE/peak convergence monitor for the LMS filter error stream
module lms_conv_monitor #(
  parameter int         WIN_LOG2 = 4,
  parameter logic [9:0] THR_LO   = 10'd16,
  parameter logic [9:0] THR_HI   = 10'd48,
  parameter int         HOLD     = 3,
  parameter logic [9:0] DIV_LIM  = 10'd500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic signed [9:0] errr,
  output logic [9:0]        mae_out,
  output logic [9:0]        peak_out,
  output logic              mae_valid,
  output logic              converged,
  output logic              lost,
  output logic              diverge,
  output logic [15:0]       win_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_LOCK  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam int AW = 10 + WIN_LOG2;

  state_t              state_q;
  logic [AW-1:0]       acc_q;
  logic [9:0]          peak_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [3:0]          good_q;
  logic [9:0]          mae_q;
  logic [9:0]          peak_out_q;
  logic                mae_valid_q;
  logic                conv_q;
  logic                lost_q;
  logic                div_q;
  logic [15:0]         win_q;

  logic [9:0]    err_u;
  logic [9:0]    abs_d;
  logic [AW-1:0] acc_d;
  logic [9:0]    peak_d;
  logic [9:0]    mae_d;
  logic [3:0]    good_d;
  logic          accept;
  logic          win_end;

  // Two's-complement negate of -512 yields 10'h200, which reads as 512 unsigned.
  always_comb begin
    err_u   = errr;
    abs_d   = errr[9] ? (~err_u + 10'd1) : err_u;
    acc_d   = acc_q + AW'(abs_d);
    peak_d  = (abs_d > peak_q) ? abs_d : peak_q;
    mae_d   = 10'(acc_d >> WIN_LOG2);
    good_d  = good_q + 4'd1;
    accept  = en && (state_q != S_FAULT);
    win_end = accept && (cnt_q == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      peak_q      <= '0;
      cnt_q       <= '0;
      good_q      <= '0;
      mae_q       <= '0;
      peak_out_q  <= '0;
      mae_valid_q <= 1'b0;
      conv_q      <= 1'b0;
      lost_q      <= 1'b0;
      div_q       <= 1'b0;
      win_q       <= '0;
    end else begin
      mae_valid_q <= 1'b0;
      lost_q      <= 1'b0;
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == S_IDLE) state_q <= S_ACQ;
        if (win_end) begin
          acc_q       <= '0;
          peak_q      <= '0;
          mae_q       <= mae_d;
          peak_out_q  <= peak_d;
          mae_valid_q <= 1'b1;
          if (win_q != 16'hFFFF) win_q <= win_q + 16'd1;
          // Divergence outranks both lock acquisition and loss of lock.
          if (peak_d >= DIV_LIM) begin
            state_q <= S_FAULT;
            div_q   <= 1'b1;
            conv_q  <= 1'b0;
          end else if (state_q == S_ACQ) begin
            if (mae_d < THR_LO) begin
              good_q <= good_d;
              if (good_d == 4'(HOLD)) begin
                state_q <= S_LOCK;
                conv_q  <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end else if (state_q == S_LOCK && mae_d >= THR_HI) begin
            state_q <= S_ACQ;
            good_q  <= '0;
            conv_q  <= 1'b0;
            lost_q  <= 1'b1;
          end
        end else begin
          acc_q  <= acc_d;
          peak_q <= peak_d;
        end
      end
    end
  end

  assign mae_out   = mae_q;
  assign peak_out  = peak_out_q;
  assign mae_valid = mae_valid_q;
  assign converged = conv_q;
  assign lost      = lost_q;
  assign diverge   = div_q;
  assign win_cnt   = win_q;
  assign state     = state_q;

endmodule
